// File: rtl/lsu_bus_master_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_master_if
// Groups the request, response and byte-lane RAM signals of lsu_bus_master.
//   req_*  : MEM-stage request (valid/ready handshake, op, address, data, tag)
//   resp_* : one-cycle completion strobe with load data, tag and error flag
//   mem_*  : byte-lane data RAM port (ce/we/addr/sel/data out, read data in)
// Modports:
//   master : the load/store unit (accepts requests, drives the RAM port)
//   slave  : its environment (issues requests, models the RAM)
// ---------------------------------------------------------------------------
interface lsu_bus_master_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_store_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;

    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic [4:0]  resp_rd_o;
    logic        resp_err_o;

    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    modport master (
        input  req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        output req_ready_o,
        output resp_valid_o, resp_rdata_o, resp_rd_o, resp_err_o,
        output mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
        input  mem_data_i
    );

    modport slave (
        output req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        input  req_ready_o,
        input  resp_valid_o, resp_rdata_o, resp_rd_o, resp_err_o,
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
        output mem_data_i
    );
endinterface

// File: rtl/lsu_bus_master.sv
// ---------------------------------------------------------------------------
// lsu_bus_master
// Load/store initiator between the MEM stage and a byte-lane data RAM.
// Accepts one RV32I load/store at a time, drives lane selects and
// lane-shifted store data, splits word-crossing accesses into two beats
// (or reports them as errors when SPLIT_EN=0) and returns extended load
// data or store completion on a one-cycle response strobe.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : lsu_bus_master_if.master (request, response and RAM port)
// All bus and response outputs are registered; req_ready_o is decoded
// from the state register.
// ---------------------------------------------------------------------------
module lsu_bus_master #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    lsu_bus_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    // Bytes touched by the access: B/BU = 1, H/HU = 2, W = 4.
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            // NOTE: every decode case ends in a default so the logic stays
            // purely combinational and no latch can be inferred.
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic illegal_op(input logic store, input logic [2:0] f3);
        if (store)
            return f3 > 3'b010;
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'h0, raw[7:0]};
            3'b101:  return {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    state_t      state;

    // Request fields captured at acceptance.
    logic        r_store;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic        r_cross;
    logic [31:0] ld_buf;

    // Registered outputs.
    logic        ce_q, we_q, rv_q, err_q;
    logic [31:0] addr_q, data_q, rdata_q;
    logic [3:0]  sel_q;
    logic [4:0]  rd_q;

    // Decode of the incoming request (used only in the accept cycle).
    logic [1:0]  req_off;
    logic [2:0]  req_size;
    logic        req_cross;
    logic        req_err;
    logic [7:0]  req_lanes;

    assign req_off   = bus.req_addr_i[1:0];
    assign req_size  = access_size(bus.req_funct3_i);
    assign req_cross = ({1'b0, req_off} + req_size) > 3'd4;
    assign req_err   = illegal_op(bus.req_store_i, bus.req_funct3_i) || (req_cross && !SPLIT_EN);
    // 8-bit lane vector: [3:0] are beat-0 lanes, [7:4] are lanes that spill
    // into the next word and become the beat-1 selects.
    assign req_lanes = {4'b0000, lane_mask(bus.req_funct3_i)} << req_off;

    // Decode of the registered request for the second beat and load capture.
    logic [1:0]  r_off;
    logic [2:0]  r_back;
    logic [7:0]  r_lanes;
    logic [31:0] beat0_rdata;
    logic [31:0] beat1_rdata;
    logic [31:0] beat1_wdata;

    assign r_off       = r_addr[1:0];
    assign r_back      = 3'd4 - {1'b0, r_off};
    assign r_lanes     = {4'b0000, lane_mask(r_f3)} << r_off;
    assign beat0_rdata = bus.mem_data_i >> {r_off, 3'b000};
    // Beat-1 bytes sit directly above the 4-off bytes taken in beat 0.
    assign beat1_rdata = bus.mem_data_i << {r_back, 3'b000};
    assign beat1_wdata = r_wdata >> {r_back, 3'b000};

    assign bus.req_ready_o  = (state == IDLE) && !rst;
    assign bus.mem_ce_o     = ce_q;
    assign bus.mem_we_o     = we_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_sel_o    = sel_q;
    assign bus.mem_data_o   = data_q;
    assign bus.resp_valid_o = rv_q;
    assign bus.resp_rdata_o = rdata_q;
    assign bus.resp_rd_o    = rd_q;
    assign bus.resp_err_o   = err_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the pre-edge value of each register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            r_store <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rd    <= 5'd0;
            r_cross <= 1'b0;
            ld_buf  <= 32'h0;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            sel_q   <= 4'b0000;
            data_q  <= 32'h0;
            rv_q    <= 1'b0;
            rdata_q <= 32'h0;
            rd_q    <= 5'd0;
            err_q   <= 1'b0;
        end else begin
            // Bus and response default to idle; states below override.
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            sel_q   <= 4'b0000;
            data_q  <= 32'h0;
            rv_q    <= 1'b0;
            rdata_q <= 32'h0;
            rd_q    <= 5'd0;
            err_q   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        r_store <= bus.req_store_i;
                        r_f3    <= bus.req_funct3_i;
                        r_addr  <= bus.req_addr_i;
                        r_wdata <= bus.req_wdata_i;
                        r_rd    <= bus.req_rd_i;
                        r_cross <= req_cross;
                        if (req_err) begin
                            state <= RESP;
                            rv_q  <= 1'b1;
                            err_q <= 1'b1;
                            rd_q  <= bus.req_rd_i;
                        end else begin
                            state  <= ACC0;
                            ce_q   <= 1'b1;
                            we_q   <= bus.req_store_i;
                            addr_q <= {bus.req_addr_i[31:2], 2'b00};
                            sel_q  <= req_lanes[3:0];
                            data_q <= bus.req_wdata_i << {req_off, 3'b000};
                        end
                    end
                end

                ACC0: begin
                    ld_buf <= beat0_rdata;
                    if (r_cross) begin
                        state  <= ACC1;
                        ce_q   <= 1'b1;
                        we_q   <= r_store;
                        addr_q <= {r_addr[31:2], 2'b00} + 32'd4;   // wraps past 0xFFFFFFFC
                        sel_q  <= r_lanes[7:4];
                        data_q <= beat1_wdata;
                    end else begin
                        state   <= RESP;
                        rv_q    <= 1'b1;
                        rd_q    <= r_rd;
                        rdata_q <= r_store ? 32'h0 : extend_load(r_f3, beat0_rdata);
                    end
                end

                ACC1: begin
                    state   <= RESP;
                    rv_q    <= 1'b1;
                    rd_q    <= r_rd;
                    rdata_q <= r_store ? 32'h0 : extend_load(r_f3, ld_buf | beat1_rdata);
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_bus_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_master
// Directed bench for lsu_bus_master. dut0 (SPLIT_EN=1) talks to a small
// byte-lane RAM model; dut1 (SPLIT_EN=0) only sees error requests. Expected
// responses and bus beats are queued at issue time and popped by a
// monitor that samples on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_lsu_bus_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic        req_dut;
    logic        req_store;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    lsu_bus_master_if bus0 ();
    lsu_bus_master_if bus1 ();

    lsu_bus_master #(.SPLIT_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    lsu_bus_master #(.SPLIT_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus0.req_valid_i  = req_valid && !req_dut;
    assign bus1.req_valid_i  = req_valid && req_dut;
    assign bus0.req_store_i  = req_store;
    assign bus1.req_store_i  = req_store;
    assign bus0.req_funct3_i = req_f3;
    assign bus1.req_funct3_i = req_f3;
    assign bus0.req_addr_i   = req_addr;
    assign bus1.req_addr_i   = req_addr;
    assign bus0.req_wdata_i  = req_wdata;
    assign bus1.req_wdata_i  = req_wdata;
    assign bus0.req_rd_i     = req_rd;
    assign bus1.req_rd_i     = req_rd;

    // RAM model: 256 words, indexed by addr[9:2].
    logic [31:0] ram [256];
    assign bus0.mem_data_i = ram[bus0.mem_addr_o[9:2]];
    assign bus1.mem_data_i = 32'h5A5AA5A5;

    always @(posedge clk) begin
        if (bus0.mem_ce_o && bus0.mem_we_o) begin
            for (int k = 0; k < 4; k++)
                if (bus0.mem_sel_o[k])
                    ram[bus0.mem_addr_o[9:2]][8*k +: 8] = bus0.mem_data_o[8*k +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        int          cycle;
    } exp_resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } exp_beat_t;

    exp_resp_t rq0[$];
    exp_resp_t rq1[$];
    exp_beat_t bq0[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard.
    exp_resp_t m_r;
    exp_beat_t m_b;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.resp_valid_o) begin
                if (rq0.size() == 0) begin
                    check("unexpected_resp0", 32'(bus0.resp_valid_o), 32'h0);
                end else begin
                    m_r = rq0.pop_front();
                    check("resp0_rdata", bus0.resp_rdata_o, m_r.rdata);
                    check("resp0_rd", 32'(bus0.resp_rd_o), 32'(m_r.rd));
                    check("resp0_err", 32'(bus0.resp_err_o), 32'(m_r.err));
                    check("resp0_cycle", 32'(cyc), 32'(m_r.cycle));
                    check("resp0_ready_low", 32'(bus0.req_ready_o), 32'h0);
                end
            end
            if (bus0.mem_ce_o) begin
                if (bq0.size() == 0) begin
                    check("unexpected_beat0", 32'(bus0.mem_ce_o), 32'h0);
                end else begin
                    m_b = bq0.pop_front();
                    check("beat0_we", 32'(bus0.mem_we_o), 32'(m_b.we));
                    check("beat0_addr", bus0.mem_addr_o, m_b.addr);
                    check("beat0_sel", 32'(bus0.mem_sel_o), 32'(m_b.sel));
                    check("beat0_data", bus0.mem_data_o, m_b.data);
                end
            end else begin
                check("idle_bus0", bus0.mem_addr_o | bus0.mem_data_o | 32'(bus0.mem_sel_o)
                      | 32'(bus0.mem_we_o), 32'h0);
            end
            if (bus1.resp_valid_o) begin
                if (rq1.size() == 0) begin
                    check("unexpected_resp1", 32'(bus1.resp_valid_o), 32'h0);
                end else begin
                    m_r = rq1.pop_front();
                    check("resp1_rdata", bus1.resp_rdata_o, m_r.rdata);
                    check("resp1_rd", 32'(bus1.resp_rd_o), 32'(m_r.rd));
                    check("resp1_err", 32'(bus1.resp_err_o), 32'(m_r.err));
                    check("resp1_cycle", 32'(cyc), 32'(m_r.cycle));
                end
            end
            if (bus1.mem_ce_o)
                check("unexpected_beat1", 32'(bus1.mem_ce_o), 32'h0);
        end
    end

    task automatic beat(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        exp_beat_t b;
        b.we = we; b.addr = a; b.sel = s; b.data = d;
        bq0.push_back(b);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((rq0.size() != 0 || rq1.size() != 0 || bq0.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check("txn_timeout", 32'(n), 32'h0);
            rq0.delete(); rq1.delete(); bq0.delete();
        end
    endtask

    // Issue one request; lat is the expected accept-to-response distance.
    task automatic issue(input logic dut, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        exp_resp_t e;
        int n;
        @(negedge clk);
        n = 0;
        while (!(dut ? bus1.req_ready_o : bus0.req_ready_o) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(n), 32'h0);
        req_dut = dut; req_store = st; req_f3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
        e.rdata = exp_rdata; e.rd = rd; e.err = exp_err; e.cycle = cyc + lat;
        if (dut) rq1.push_back(e);
        else     rq0.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_dut = 1'b0; req_store = 1'b0;
        req_f3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[64]  = 32'h8899AABB;   // 0x100
        ram[65]  = 32'h11223344;   // 0x104
        ram[255] = 32'hCAFEF00D;   // 0xFFFFFFFC
        ram[0]   = 32'h76543210;   // 0x00000000

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus0.req_ready_o), 32'h0);
        check("rst_ce", 32'(bus0.mem_ce_o), 32'h0);
        check("rst_resp_valid", 32'(bus0.resp_valid_o), 32'h0);
        check("rst_rdata", bus0.resp_rdata_o, 32'h0);
        check("rst_addr", bus0.mem_addr_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus0.req_ready_o), 32'h1);

        // Aligned and sub-word loads from 0x8899AABB at 0x100.
        beat(0, 32'h100, 4'b1111, 32'h0); issue(0, 0, 3'b010, 32'h100, 32'h0, 5'd1, 32'h8899AABB, 0, 2);
        beat(0, 32'h100, 4'b1000, 32'h0); issue(0, 0, 3'b000, 32'h103, 32'h0, 5'd2, 32'hFFFFFF88, 0, 2);
        beat(0, 32'h100, 4'b1000, 32'h0); issue(0, 0, 3'b100, 32'h103, 32'h0, 5'd3, 32'h00000088, 0, 2);
        beat(0, 32'h100, 4'b1100, 32'h0); issue(0, 0, 3'b001, 32'h102, 32'h0, 5'd4, 32'hFFFF8899, 0, 2);
        beat(0, 32'h100, 4'b0011, 32'h0); issue(0, 0, 3'b101, 32'h100, 32'h0, 5'd5, 32'h0000AABB, 0, 2);

        // SH 0x105 then readback with neighbours preserved.
        beat(1, 32'h104, 4'b0110, 32'h00123400); issue(0, 1, 3'b001, 32'h105, 32'h00001234, 5'd6, 32'h0, 0, 2);
        beat(0, 32'h104, 4'b1111, 32'h0); issue(0, 0, 3'b010, 32'h104, 32'h0, 5'd7, 32'h11123444, 0, 2);

        // Split SW 0x102, then split LW 0x102.
        beat(1, 32'h100, 4'b1100, 32'hBEEF0000);
        beat(1, 32'h104, 4'b0011, 32'h0000DEAD);
        issue(0, 1, 3'b010, 32'h102, 32'hDEADBEEF, 5'd8, 32'h0, 0, 3);
        beat(0, 32'h100, 4'b1100, 32'h0);
        beat(0, 32'h104, 4'b0011, 32'h0);
        issue(0, 0, 3'b010, 32'h102, 32'h0, 5'd9, 32'hDEADBEEF, 0, 3);

        // Split LH 0x103: 0xBE from 0x103, 0xAD from 0x104.
        beat(0, 32'h100, 4'b1000, 32'h0);
        beat(0, 32'h104, 4'b0001, 32'h0);
        issue(0, 0, 3'b001, 32'h103, 32'h0, 5'd10, 32'hFFFFADBE, 0, 3);

        // LW 0xFFFFFFFE wraps to address 0 for beat 1.
        beat(0, 32'hFFFFFFFC, 4'b1100, 32'h0);
        beat(0, 32'h00000000, 4'b0011, 32'h0);
        issue(0, 0, 3'b010, 32'hFFFFFFFE, 32'h0, 5'd11, 32'h3210CAFE, 0, 3);

        // Illegal encodings: no bus beat, error at T+1.
        issue(0, 0, 3'b011, 32'h100, 32'h0, 5'd12, 32'h0, 1, 1);
        issue(0, 1, 3'b011, 32'h100, 32'hFFFFFFFF, 5'd13, 32'h0, 1, 1);
        issue(0, 1, 3'b100, 32'h100, 32'hFFFFFFFF, 5'd14, 32'h0, 1, 1);

        // SB to lane 3 drops the upper wdata bytes; LB reads back positive.
        beat(1, 32'h104, 4'b1000, 32'h7E000000); issue(0, 1, 3'b000, 32'h107, 32'hFFFFFF7E, 5'd15, 32'h0, 0, 2);
        beat(0, 32'h104, 4'b1000, 32'h0); issue(0, 0, 3'b000, 32'h107, 32'h0, 5'd16, 32'h0000007E, 0, 2);

        // SPLIT_EN=0: crossing access and bad load funct3 both error at T+1.
        issue(1, 0, 3'b001, 32'h103, 32'h0, 5'd17, 32'h0, 1, 1);
        issue(1, 0, 3'b111, 32'h100, 32'h0, 5'd18, 32'h0, 1, 1);

        // Reset during ACC1 of a split SW 0x10A.
        beat(1, 32'h108, 4'b1100, 32'hC3D40000);
        beat(1, 32'h10C, 4'b0011, 32'h0000A1B2);
        @(negedge clk);
        check("mid_rst_ready_before", 32'(bus0.req_ready_o), 32'h1);
        req_dut = 1'b0; req_store = 1'b1; req_f3 = 3'b010; req_addr = 32'h10A;
        req_wdata = 32'hA1B2C3D4; req_rd = 5'd19; req_valid = 1'b1;
        @(negedge clk);                  // ACC0
        req_valid = 1'b0;
        @(negedge clk);                  // ACC1
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ce", 32'(bus0.mem_ce_o), 32'h0);
        check("mid_rst_resp", 32'(bus0.resp_valid_o), 32'h0);
        check("mid_rst_ready", 32'(bus0.req_ready_o), 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_after", 32'(bus0.req_ready_o), 32'h1);
        check("mid_rst_beats_seen", 32'(bq0.size()), 32'h0);
        check("mid_rst_beat0_kept", ram[66], 32'hC3D40000);
        beat(0, 32'h108, 4'b1111, 32'h0); issue(0, 0, 3'b010, 32'h108, 32'h0, 5'd20, 32'hC3D40000, 0, 2);

        repeat (4) @(negedge clk);
        check("no_pending_resp", 32'(rq0.size() + rq1.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
